sticker_scan_sequencer: RTL
===========================

// Module: sticker_scan_sequencer
// PURPOSE
// Parametrised successor to the fixed 48-sticker scan FSM. It steps the motor controller through one setup
// move per sticker, takes VOTES colour samples per sticker, and resolves them by plurality vote with retry.
// Results pack into a cube-state vector with the centre colours hard-wired, followed by a per-colour count check.
// Sits between the colour sensor front-end, the move sequencer (spin_all) and the solver input.
// PARAMETERS
// NUM_STICKERS  48  non-centre stickers scanned (multiple of 6)
// COLOR_W       3   bits per colour code
// VOTES         4   samples per sticker (1..8); VOTES=1 disables voting
// MAX_RETRY     2   extra full vote passes when no plurality exists
// STEP_W        7   width of move_step index
// PORTS
// clock          in   1                            system clock
// reset_n        in   1                            async active-low reset
// start          in   1                            level; sampled in IDLE only
// abort          in   1                            1-cycle; returns to IDLE from any state
// sensor_color   in   COLOR_W                      colour under sensor
// sensor_stable  in   1                            sensor settled after move
// move_done      in   1                            1-cycle pulse: requested move finished
// move_req       out  1                            1-cycle pulse: execute move_step
// move_step      out  STEP_W                       move index sent to spin_all
// sticker_idx    out  $clog2(NUM_STICKERS+1)       sticker being scanned
// state_out      out  (NUM_STICKERS+6)*COLOR_W     centres in top 6 fields, stickers below
// state_valid    out  1                            high in DONE until start/abort
// busy           out  1                            high outside IDLE/DONE
// vote_fail      out  1                            sticky: some sticker stored without plurality
// count_error    out  1                            some colour count != NUM_STICKERS/6
// BEHAVIOUR
// - Reset: all outputs 0, except state_out = centres {Y,B,R,G,O,W} over zeros. FSM -> IDLE; counters 0.
// - States: IDLE, REQ, WAITMV, WAITST, SAMPLE, VOTE, STORE, FINAL, CHECK, DONE.
// - IDLE: on start=1 clear sticker field, sticker_idx=0, vote_fail=0, count_error=0; -> REQ.
// - REQ: move_req=1 for exactly one cycle; -> WAITMV.
//   - move_step = sticker_idx when sample k=0.
//   - move_step = NUM_STICKERS+k-1 when k>0 (resample move).
// - WAITMV: wait for move_done; a move_done on the REQ cycle itself counts. -> WAITST.
// - WAITST: wait for sensor_stable=1; -> SAMPLE.
// - SAMPLE: latch sensor_color into slot k.
//   - k<VOTES-1: k++, -> REQ.
//   - else -> VOTE.
// - VOTE (1 cycle): winner = value with highest count across valid slots.
//   - Code 7 (NULL) is never counted.
//   - Ties go to the value seen at the lowest slot index.
//   - max count>=2 or VOTES==1: -> STORE.
//   - Otherwise, if retry<MAX_RETRY: retry++, k=0, -> REQ.
//   - Otherwise: winner = slot VOTES-1, set vote_fail, -> STORE.
// - STORE: shift state_out sticker field left COLOR_W, insert winner at LSBs; retry=0, k=0, sticker_idx++.
//   - sticker_idx==NUM_STICKERS -> FINAL.
//   - else -> REQ.
// - FINAL: move_req with move_step=NUM_STICKERS+VOTES-1 (restore move); wait move_done; -> CHECK.
// - CHECK: histogram of the NUM_STICKERS fields, one field per cycle (NUM_STICKERS cycles).
//   - count_error=1 if any colour 0..5 count != NUM_STICKERS/6.
//   - -> DONE.
// - DONE: state_valid=1, state_out held; start=1 restarts the scan (as from IDLE).
// - abort (any state): -> IDLE same edge.
//   - state_valid=0, move_req=0, busy=0.
//   - state_out partial contents retained; a move already in flight is not cancelled.
// - start while busy: ignored. move_done outside WAITMV/FINAL: ignored.
// - Latency with instant move_done/stable: 4 cycles per sample, +1 VOTE +1 STORE per sticker.
// - Counters saturate; no wrap of sticker_idx beyond NUM_STICKERS.
// STRUCTURE
// - Shared package cube_pkg: colour codes W=0,O=1,G=2,R=3,B=4,Y=5,NULL=7; COLOR_W; CENTRE_INIT constant.
// - Sub-module color_vote: combinational plurality over VOTES slots.
//   - Ports: slots, valid mask, winner, max_count.
// - Sub-module instantiated once; the histogram in CHECK reuses a single 6-entry counter bank.
// TESTING
// - Clean scan, VOTES=4, model returns colour i%6 for sticker i:
//   state_out = centres + expected fields; state_valid after CHECK; count_error=0; 4*48+1 move_req pulses.
// - Samples {R,G,R,B}: stores R.
//   - Samples {G,B,B,G}: stores G (tie, lowest index).
//   - Samples {NULL,NULL,Y,O}: no plurality -> retry.
// - Sticker 5 returns 4 distinct colours on every pass, MAX_RETRY=2:
//   3 passes (12 samples); stores last sample; vote_fail=1; scan continues.
// - One sticker forced W instead of Y: scan completes, count_error=1, state_valid=1.
// - abort during WAITST of sticker 20: next cycle busy=0, state_valid=0, no further move_req; start restarts at idx 0.
// - reset_n asserted mid-VOTE asynchronously: outputs immediately at reset values; VOTES=1 build needs no retry.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared cube colour codes, centre layout and scan FSM encoding
// for the sticker scan sequencer and its voting helper.
package cube_pkg;

   localparam int COLOR_W = 3;

   localparam logic [COLOR_W-1:0] C_W    = 3'd0;
   localparam logic [COLOR_W-1:0] C_O    = 3'd1;
   localparam logic [COLOR_W-1:0] C_G    = 3'd2;
   localparam logic [COLOR_W-1:0] C_R    = 3'd3;
   localparam logic [COLOR_W-1:0] C_B    = 3'd4;
   localparam logic [COLOR_W-1:0] C_Y    = 3'd5;
   localparam logic [COLOR_W-1:0] C_NULL = 3'd7;

   localparam logic [6*COLOR_W-1:0] CENTRE_INIT =
      {C_Y, C_B, C_R, C_G, C_O, C_W};

   typedef enum logic [3:0] {
      S_IDLE,
      S_REQ,
      S_WAITMV,
      S_WAITST,
      S_SAMPLE,
      S_VOTE,
      S_STORE,
      S_FINAL,
      S_CHECK,
      S_DONE
   } scan_state_e;

endpackage

// File: rtl/color_vote.sv
// Combinational plurality vote over the colour sample slots.
// NULL samples never score; ties resolve to the lowest slot.
module color_vote #(
   parameter int COLOR_W = 3,
   parameter int VOTES   = 4,
   parameter int CNT_W   = $clog2(VOTES + 1)
) (
   input  logic [VOTES*COLOR_W-1:0] slots_i,
   input  logic [VOTES-1:0]         valid_i,
   output logic [COLOR_W-1:0]       winner_o,
   output logic [CNT_W-1:0]         max_count_o
);

   import cube_pkg::*;

   localparam logic [COLOR_W-1:0] NULL_C = COLOR_W'(C_NULL);

   logic [COLOR_W-1:0] a;
   logic [COLOR_W-1:0] b;
   logic [CNT_W-1:0]   cnt;

   always_comb begin
      winner_o    = NULL_C;
      max_count_o = '0;
      a           = '0;
      b           = '0;
      cnt         = '0;
      for (int i = 0; i < VOTES; i++) begin
         a   = slots_i[i*COLOR_W +: COLOR_W];
         cnt = '0;
         for (int j = 0; j < VOTES; j++) begin
            b = slots_i[j*COLOR_W +: COLOR_W];
            if (valid_i[j] && b == a)
               cnt = cnt + CNT_W'(1);
         end
         // strict compare keeps the earliest slot on a tie
         if (valid_i[i] && a != NULL_C && cnt > max_count_o) begin
            max_count_o = cnt;
            winner_o    = a;
         end
      end
   end

endmodule

// File: rtl/sticker_scan_sequencer.sv
// Steps the motor through each sticker, votes colour samples,
// packs the cube state and checks per-colour counts.
module sticker_scan_sequencer #(
   parameter int NUM_STICKERS = 48,
   parameter int COLOR_W      = 3,
   parameter int VOTES        = 4,
   parameter int MAX_RETRY    = 2,
   parameter int STEP_W       = 7
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic                                abort,
   input  logic [COLOR_W-1:0]                  sensor_color,
   input  logic                                sensor_stable,
   input  logic                                move_done,
   output logic                                move_req,
   output logic [STEP_W-1:0]                   move_step,
   output logic [$clog2(NUM_STICKERS+1)-1:0]   sticker_idx,
   output logic [(NUM_STICKERS+6)*COLOR_W-1:0] state_out,
   output logic                                state_valid,
   output logic                                busy,
   output logic                                vote_fail,
   output logic                                count_error
);

   import cube_pkg::*;

   localparam int IDX_W = $clog2(NUM_STICKERS + 1);
   localparam int K_W   = $clog2(VOTES + 1);
   localparam int R_W   = $clog2(MAX_RETRY + 2);
   localparam int FW    = NUM_STICKERS * COLOR_W;
   localparam int SW    = VOTES * COLOR_W;
   localparam logic [6*COLOR_W-1:0] CENTRES = CENTRE_INIT;

   scan_state_e        state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [R_W-1:0]     retry_q, retry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   chk_q, chk_d;
   logic [SW-1:0]      slots_q, slots_d;
   logic [VOTES-1:0]   valid_q, valid_d;
   logic [FW-1:0]      stk_q, stk_d;
   logic               vfail_q, vfail_d;
   logic               cerr_q, cerr_d;
   logic               seen_q, seen_d;
   logic               fin_q, fin_d;
   logic [IDX_W-1:0]   hist_q [6];
   logic [IDX_W-1:0]   hist_d [6];

   logic [COLOR_W-1:0] winner;
   logic [K_W-1:0]     max_cnt;
   logic [COLOR_W-1:0] store_c;
   logic [COLOR_W-1:0] fld;
   logic               plural;
   logic               bad;

   color_vote #(
      .COLOR_W (COLOR_W),
      .VOTES   (VOTES),
      .CNT_W   (K_W)
   ) u_vote (
      .slots_i     (slots_q),
      .valid_i     (valid_q),
      .winner_o    (winner),
      .max_count_o (max_cnt)
   );

   assign plural  = (int'(max_cnt) >= 2) || (VOTES == 1);
   // without a plurality the most recent sample is kept
   assign store_c = (int'(max_cnt) >= 2) ? winner
                  : slots_q[(VOTES-1)*COLOR_W +: COLOR_W];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         retry_q <= '0;
         idx_q   <= '0;
         chk_q   <= '0;
         slots_q <= '0;
         valid_q <= '0;
         stk_q   <= '0;
         vfail_q <= 1'b0;
         cerr_q  <= 1'b0;
         seen_q  <= 1'b0;
         fin_q   <= 1'b0;
         for (int c = 0; c < 6; c++) hist_q[c] <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         retry_q <= retry_d;
         idx_q   <= idx_d;
         chk_q   <= chk_d;
         slots_q <= slots_d;
         valid_q <= valid_d;
         stk_q   <= stk_d;
         vfail_q <= vfail_d;
         cerr_q  <= cerr_d;
         seen_q  <= seen_d;
         fin_q   <= fin_d;
         for (int c = 0; c < 6; c++) hist_q[c] <= hist_d[c];
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      retry_d   = retry_q;
      idx_d     = idx_q;
      chk_d     = chk_q;
      slots_d   = slots_q;
      valid_d   = valid_q;
      stk_d     = stk_q;
      vfail_d   = vfail_q;
      cerr_d    = cerr_q;
      seen_d    = seen_q;
      fin_d     = fin_q;
      hist_d    = hist_q;
      move_req  = 1'b0;
      move_step = '0;
      fld       = '0;
      bad       = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         seen_d  = 1'b0;
         fin_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  stk_d   = '0;
                  idx_d   = '0;
                  k_d     = '0;
                  retry_d = '0;
                  valid_d = '0;
                  vfail_d = 1'b0;
                  cerr_d  = 1'b0;
                  state_d = S_REQ;
               end
            end
            S_REQ: begin
               move_req  = 1'b1;
               move_step = (k_q == '0) ? STEP_W'(idx_q)
                         : STEP_W'(NUM_STICKERS + int'(k_q) - 1);
               seen_d    = move_done;
               state_d   = S_WAITMV;
            end
            S_WAITMV: begin
               if (move_done || seen_q) begin
                  seen_d  = 1'b0;
                  state_d = S_WAITST;
               end
            end
            S_WAITST: begin
               if (sensor_stable) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
               slots_d[int'(k_q)*COLOR_W +: COLOR_W] = sensor_color;
               valid_d[int'(k_q) +: 1] = 1'b1;
               if (int'(k_q) < VOTES - 1) begin
                  k_d     = k_q + K_W'(1);
                  state_d = S_REQ;
               end else begin
                  state_d = S_VOTE;
               end
            end
            S_VOTE: begin
               if (plural) begin
                  state_d = S_STORE;
               end else if (int'(retry_q) < MAX_RETRY) begin
                  retry_d = retry_q + R_W'(1);
                  k_d     = '0;
                  valid_d = '0;
                  state_d = S_REQ;
               end else begin
                  vfail_d = 1'b1;
                  state_d = S_STORE;
               end
            end
            S_STORE: begin
               stk_d   = {stk_q[FW-COLOR_W-1:0], store_c};
               retry_d = '0;
               k_d     = '0;
               valid_d = '0;
               if (int'(idx_q) < NUM_STICKERS)
                  idx_d = idx_q + IDX_W'(1);
               state_d = (int'(idx_q) >= NUM_STICKERS - 1) ? S_FINAL
                                                            : S_REQ;
            end
            S_FINAL: begin
               move_req  = !fin_q;
               move_step = STEP_W'(NUM_STICKERS + VOTES - 1);
               fin_d     = 1'b1;
               if (move_done) begin
                  fin_d   = 1'b0;
                  chk_d   = '0;
                  for (int c = 0; c < 6; c++) hist_d[c] = '0;
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               fld = stk_q[int'(chk_q)*COLOR_W +: COLOR_W];
               for (int c = 0; c < 6; c++)
                  if (fld == COLOR_W'(c))
                     hist_d[c] = hist_q[c] + IDX_W'(1);
               if (int'(chk_q) == NUM_STICKERS - 1) begin
                  for (int c = 0; c < 6; c++)
                     if (hist_d[c] != IDX_W'(NUM_STICKERS / 6))
                        bad = 1'b1;
                  cerr_d  = bad;
                  state_d = S_DONE;
               end else begin
                  chk_d = chk_q + IDX_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign sticker_idx = idx_q;
   assign state_out   = {CENTRES, stk_q};
   assign state_valid = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign vote_fail   = vfail_q;
   assign count_error = cerr_q;

endmodule
